// File: rtl/tick_rate_controller.sv
// Game-tick source derived from CLOCK_50: run/pause, single-step while paused,
// and speed levels that halve the tick period per level. Also drives a legacy slow_clock.
module tick_rate_controller #(
    parameter int unsigned BASE_DIV = 6108864,
    parameter int unsigned LEVELS   = 4,
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned LVL_W    = 2
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic             run,
    input  logic             step,
    input  logic             speed_up,
    input  logic             slow_down,
    output logic             tick,
    output logic             slow_clock,
    output logic             running,
    output logic [LVL_W-1:0] speed_level,
    output logic [15:0]      tick_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] BASE_C    = CNT_W'(BASE_DIV);
    localparam logic [LVL_W-1:0] LEVEL_MAX = LVL_W'(LEVELS - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] counter_q, counter_d;
    logic [LVL_W-1:0] pending_q, pending_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             tick_q, tick_d;
    logic             slow_q, slow_d;
    logic             running_q, running_d;
    logic [15:0]      count_q, count_d;

    logic [CNT_W-1:0] period_m1;
    logic             terminal;

    // The applied level only changes at a tick boundary, so the terminal
    // count is stable for the whole period.
    always_comb begin
        period_m1 = (BASE_C >> level_q) - CNT_W'(1);
        terminal  = (counter_q == period_m1);
    end

    // Requested level: each sampled pulse counts once; opposing pulses cancel.
    always_comb begin
        pending_d = pending_q;
        if (speed_up && !slow_down && (pending_q != LEVEL_MAX)) begin
            pending_d = pending_q + LVL_W'(1);
        end else if (slow_down && !speed_up && (pending_q != '0)) begin
            pending_d = pending_q - LVL_W'(1);
        end
    end

    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        level_d   = level_q;
        tick_d    = 1'b0;
        slow_d    = slow_q;
        count_d   = count_q;

        case (state_q)
            IDLE: begin
                counter_d = '0;
                level_d   = pending_q;
                if (run) begin
                    state_d = RUN;
                end else if (step) begin
                    state_d = STEP;
                end
            end

            STEP: begin
                counter_d = '0;
                tick_d    = 1'b1;
                slow_d    = ~slow_q;
                count_d   = count_q + 16'd1;
                state_d   = run ? RUN : IDLE;
            end

            RUN: begin
                // Dropping run discards the partial period, even at terminal count.
                if (!run) begin
                    state_d   = IDLE;
                    counter_d = '0;
                end else if (terminal) begin
                    counter_d = '0;
                    tick_d    = 1'b1;
                    slow_d    = ~slow_q;
                    count_d   = count_q + 16'd1;
                    level_d   = pending_q;
                end else begin
                    counter_d = counter_q + CNT_W'(1);
                end
            end

            default: begin
                state_d   = IDLE;
                counter_d = '0;
            end
        endcase

        running_d = (state_d == RUN);
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q   <= IDLE;
            counter_q <= '0;
            pending_q <= '0;
            level_q   <= '0;
            tick_q    <= 1'b0;
            slow_q    <= 1'b0;
            running_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            pending_q <= pending_d;
            level_q   <= level_d;
            tick_q    <= tick_d;
            slow_q    <= slow_d;
            running_q <= running_d;
            count_q   <= count_d;
        end
    end

    assign tick        = tick_q;
    assign slow_clock  = slow_q;
    assign running     = running_q;
    assign speed_level = level_q;
    assign tick_count  = count_q;

endmodule

// File: tb/tb_tick_rate_controller.sv
// Directed bench for tick_rate_controller with BASE_DIV=8, LEVELS=4
// (periods 8, 4, 2, 1 cycles).
module tb_tick_rate_controller;

    logic        clk;
    logic        reset;
    logic        run;
    logic        step;
    logic        speed_up;
    logic        slow_down;
    logic        tick;
    logic        slow_clock;
    logic        running;
    logic [1:0]  speed_level;
    logic [15:0] tick_count;

    int checks = 0;
    int errors = 0;

    tick_rate_controller #(
        .BASE_DIV (8),
        .LEVELS   (4),
        .CNT_W    (32),
        .LVL_W    (2)
    ) dut (
        .CLOCK_50    (clk),
        .reset       (reset),
        .run         (run),
        .step        (step),
        .speed_up    (speed_up),
        .slow_down   (slow_down),
        .tick        (tick),
        .slow_clock  (slow_clock),
        .running     (running),
        .speed_level (speed_level),
        .tick_count  (tick_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       run;
        logic       step;
        logic       su;
        logic       sd;
        logic       exp_tick;
        logic       exp_running;
        logic [1:0] exp_level;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        run       = 1'b0;
        step      = 1'b0;
        speed_up  = 1'b0;
        slow_down = 1'b0;
        clk1();
        clk1();
        reset = 1'b0;
    endtask

    initial begin
        // Level walk in IDLE: speed_level follows pending_level one edge later.
        vecs[0]  = '{0, 0, 1, 0, 0, 0, 2'd0};
        vecs[1]  = '{0, 0, 0, 0, 0, 0, 2'd1};
        vecs[2]  = '{0, 0, 1, 0, 0, 0, 2'd1};
        vecs[3]  = '{0, 0, 0, 0, 0, 0, 2'd2};
        vecs[4]  = '{0, 0, 1, 1, 0, 0, 2'd2};
        vecs[5]  = '{0, 0, 0, 0, 0, 0, 2'd2};
        vecs[6]  = '{0, 0, 0, 1, 0, 0, 2'd2};
        vecs[7]  = '{0, 0, 0, 0, 0, 0, 2'd1};
        vecs[8]  = '{0, 0, 0, 1, 0, 0, 2'd1};
        vecs[9]  = '{0, 0, 0, 1, 0, 0, 2'd0};
        vecs[10] = '{0, 0, 0, 1, 0, 0, 2'd0};
        vecs[11] = '{0, 0, 0, 0, 0, 0, 2'd0};
        vecs[12] = '{0, 0, 1, 0, 0, 0, 2'd0};
        vecs[13] = '{0, 0, 1, 0, 0, 0, 2'd1};
        vecs[14] = '{0, 0, 1, 0, 0, 0, 2'd2};
        vecs[15] = '{0, 0, 1, 0, 0, 0, 2'd3};
        vecs[16] = '{0, 0, 0, 0, 0, 0, 2'd3};

        // Reset state
        do_reset();
        chk("rst_tick", tick, 0);
        chk("rst_slow", slow_clock, 0);
        chk("rst_running", running, 0);
        chk("rst_level", speed_level, 0);
        chk("rst_count", tick_count, 0);

        // 1. Run timing: ticks at RUN cycles 8, 16, 24
        run = 1'b1;
        clk1();
        chk("t1_running", running, 1);
        for (int k = 1; k <= 24; k++) begin
            clk1();
            chk($sformatf("t1_tick_c%0d", k), tick, (k % 8 == 0) ? 1 : 0);
            if (k == 8)  chk("t1_slow_c8", slow_clock, 1);
            if (k == 16) chk("t1_slow_c16", slow_clock, 0);
            if (k == 24) chk("t1_slow_c24", slow_clock, 1);
        end
        chk("t1_count", tick_count, 3);
        chk("t1_running_end", running, 1);

        // 2. Speed-up applied at the tick boundary, then saturation at period 1
        do_reset();
        run = 1'b1;
        clk1();
        for (int k = 1; k <= 3; k++) clk1();
        speed_up = 1'b1;
        clk1();
        speed_up = 1'b0;
        for (int k = 4; k <= 16; k++) begin
            if (k > 4) clk1();
            chk($sformatf("t2_tick_c%0d", k), tick, (k == 8 || k == 12 || k == 16) ? 1 : 0);
            chk($sformatf("t2_level_c%0d", k), speed_level, (k < 8) ? 0 : 1);
        end
        speed_up = 1'b1;
        for (int k = 17; k <= 19; k++) begin
            clk1();
            chk($sformatf("t2_tick_c%0d", k), tick, 0);
            chk($sformatf("t2_level_c%0d", k), speed_level, 1);
        end
        speed_up = 1'b0;
        for (int k = 20; k <= 25; k++) begin
            clk1();
            chk($sformatf("t2_tick_c%0d", k), tick, 1);
            chk($sformatf("t2_level_c%0d", k), speed_level, 3);
            chk($sformatf("t2_slow_c%0d", k), slow_clock, (k % 2 == 1) ? 1 : 0);
        end
        chk("t2_count", tick_count, 9);

        // 3. Pause discards the partial period; step in IDLE; step ignored in RUN
        do_reset();
        run = 1'b1;
        clk1();
        for (int k = 1; k <= 5; k++) clk1();
        run = 1'b0;
        clk1();
        chk("t3_pause_tick", tick, 0);
        chk("t3_pause_running", running, 0);
        for (int k = 0; k < 4; k++) begin
            clk1();
            chk($sformatf("t3_idle_tick%0d", k), tick, 0);
        end
        run = 1'b1;
        clk1();
        chk("t3_resume_running", running, 1);
        for (int k = 1; k <= 8; k++) begin
            clk1();
            chk($sformatf("t3_resume_tick_c%0d", k), tick, (k == 8) ? 1 : 0);
        end
        chk("t3_resume_count", tick_count, 1);
        run = 1'b0;
        clk1();
        chk("t3_idle_running", running, 0);
        step = 1'b1;
        clk1();
        step = 1'b0;
        chk("t3_step_e1_tick", tick, 0);
        clk1();
        chk("t3_step_e2_tick", tick, 1);
        chk("t3_step_count", tick_count, 2);
        chk("t3_step_slow", slow_clock, 0);
        clk1();
        chk("t3_step_e3_tick", tick, 0);
        chk("t3_step_count_hold", tick_count, 2);
        run = 1'b1;
        clk1();
        clk1();
        clk1();
        step = 1'b1;
        clk1();
        step = 1'b0;
        for (int k = 3; k <= 8; k++) begin
            if (k > 3) clk1();
            chk($sformatf("t3_runstep_tick_c%0d", k), tick, (k == 8) ? 1 : 0);
        end
        chk("t3_runstep_count", tick_count, 3);

        // 4. Level saturation and conflicting pulses, table-driven in IDLE
        do_reset();
        for (int i = 0; i < 17; i++) begin
            run       = vecs[i].run;
            step      = vecs[i].step;
            speed_up  = vecs[i].su;
            slow_down = vecs[i].sd;
            clk1();
            chk($sformatf("t4_v%0d_tick", i), tick, vecs[i].exp_tick);
            chk($sformatf("t4_v%0d_running", i), running, vecs[i].exp_running);
            chk($sformatf("t4_v%0d_level", i), speed_level, vecs[i].exp_level);
        end
        speed_up  = 1'b0;
        slow_down = 1'b0;

        // 5. Reset on the terminal-count cycle suppresses the tick
        do_reset();
        run = 1'b1;
        clk1();
        for (int k = 1; k <= 7; k++) clk1();
        reset = 1'b1;
        clk1();
        chk("t5_tick", tick, 0);
        chk("t5_slow", slow_clock, 0);
        chk("t5_count", tick_count, 0);
        chk("t5_running", running, 0);
        reset = 1'b0;
        run   = 1'b0;
        clk1();
        clk1();
        chk("t5_idle_running", running, 0);
        chk("t5_idle_tick", tick, 0);
        run = 1'b1;
        clk1();
        chk("t5_run_running", running, 1);
        for (int k = 1; k <= 8; k++) begin
            clk1();
            chk($sformatf("t5_tick_c%0d", k), tick, (k == 8) ? 1 : 0);
        end

        // 6. tick_count wrap at period 1
        do_reset();
        speed_up = 1'b1;
        clk1();
        clk1();
        clk1();
        speed_up = 1'b0;
        clk1();
        chk("t6_level", speed_level, 3);
        run = 1'b1;
        clk1();
        chk("t6_c0_tick", tick, 0);
        clk1();
        chk("t6_c1_tick", tick, 1);
        chk("t6_c1_count", tick_count, 1);
        repeat (65534) clk1();
        chk("t6_count_ffff", tick_count, 16'hFFFF);
        clk1();
        chk("t6_count_wrap", tick_count, 0);
        chk("t6_slow_phase", slow_clock, 0);
        chk("t6_tick", tick, 1);
        run = 1'b0;
        clk1();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
